fetch_sequencer: RTL and testbench

Instruction-fetch controller for the BaLuGa core. It owns the 8-bit program counter and drives the combinational instruction ROM address. Each ROM word is captured into a registered output stage with a valid/ready handshake to the decoder. It also handles branch redirects, halt-opcode detection, and start/restart.

---
 rtl/baluga_pkg.sv | 20 ++
 rtl/fetch_sequencer.sv | 116 +++++++++++
 tb/tb_fetch_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/baluga_pkg.sv
// Shared definitions for the BaLuGa core: datapath widths, opcode field
// position and the fetch state encoding.
package baluga_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 9;

    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 5;
    localparam int OPC_W   = 4;

    localparam logic [OPC_W-1:0] HALT_OPCODE = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// BaLuGa instruction-fetch controller: PC, ROM addressing, registered output stage.
// Define FETCH_PERF_CNT_EN to build the saturating fetched-instruction counter.
module fetch_sequencer #(
    parameter int                      ADDR_W      = baluga_pkg::ADDR_W,
    parameter int                      INSTR_W     = baluga_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]       START_ADDR  = 8'd0,
    parameter logic [baluga_pkg::OPC_W-1:0] HALT_OPCODE = baluga_pkg::HALT_OPCODE
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [INSTR_W-1:0] rom_instruction,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               halted,
    output logic [15:0]        fetch_count
);
    import baluga_pkg::*;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic              load;
    logic              redirect_take;
    logic              start_take;

    always_comb begin
        state_next    = state;
        load          = 1'b0;
        redirect_take = 1'b0;
        start_take    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_take = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                // Redirect outranks both the load and any halt word it would capture.
                if (redirect_valid) begin
                    redirect_take = 1'b1;
                end else if (!instr_valid || instr_ready) begin
                    load = 1'b1;
                    if (rom_instruction[OPC_MSB:OPC_LSB] == HALT_OPCODE) begin
                        state_next = HALT;
                    end
                end
            end
            HALT: begin
                if (start) begin
                    start_take = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= '0;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (load) begin
            instr_out   <= rom_instruction;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + ADDR_W'(1);
        end else if (redirect_take) begin
            pc          <= redirect_target;
            instr_valid <= 1'b0;
        end else if (start_take) begin
            pc          <= START_ADDR;
            instr_valid <= 1'b0;
        end else if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

    assign rom_address = pc;
    assign halted      = (state == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (start_take) begin
            count <= '0;
        end else if (load && (count != '1)) begin
            count <= count + 16'd1;
        end
    end

    assign fetch_count = count;
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, hand-written
// halt/reset sequences, and randomized traffic against a behavioural model.
module tb_fetch_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] rom_address;
    logic [8:0] rom_instruction;
    logic [8:0] instr_out;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_target = '0;
    logic       halted;
    logic [15:0] fetch_count;

    logic [8:0] rom [256];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    assign rom_instruction = rom[rom_address];

    fetch_sequencer #(
        .START_ADDR (8'd0)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .rom_address     (rom_address),
        .rom_instruction (rom_instruction),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    // Behavioural reference: mode 0 = idle, 1 = running, 2 = halted.
    int         m_mode;
    logic [7:0] m_pc;
    logic [7:0] m_ipc;
    logic [8:0] m_out;
    logic       m_valid;
    int         m_cnt;

    typedef struct {
        logic        start;
        logic        ready;
        logic        rv;
        logic [7:0]  tgt;
        logic        exp_valid;
        logic [7:0]  exp_pc;
        logic [7:0]  exp_addr;
        logic        exp_halted;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] cnt_exp(input int c);
`ifdef FETCH_PERF_CNT_EN
        return (c > 65535) ? 16'hFFFF : 16'(c);
`else
        return (c < 0) ? 16'hFFFF : 16'h0;
`endif
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_ipc = 0; m_out = 0; m_valid = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic s, input logic r, input logic rv, input logic [7:0] t);
        logic [8:0] w;
        w = rom[m_pc];
        if (m_mode == 1) begin
            if (rv) begin
                m_pc = t;
                m_valid = 0;
            end else if (!m_valid || r) begin
                m_out = w;
                m_ipc = m_pc;
                m_valid = 1;
                m_pc = m_pc + 8'd1;
                m_cnt = m_cnt + 1;
                if (w[8:5] == 4'hF) m_mode = 2;
            end
        end else begin
            if (m_valid && r) m_valid = 0;
            if (s) begin
                m_mode = 1;
                m_pc = 8'd0;
                m_valid = 0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic step(input logic s, input logic r, input logic rv, input logic [7:0] t);
        start = s; instr_ready = r; redirect_valid = rv; redirect_target = t;
        model_edge(s, r, rv, t);
        @(posedge clock);
        #1;
        start = 1'b0; redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".valid"}, 32'(instr_valid), 32'(m_valid));
        check({tag, ".addr"}, 32'(rom_address), 32'(m_pc));
        check({tag, ".halted"}, 32'(halted), 32'(m_mode == 2));
        check({tag, ".cnt"}, 32'(fetch_count), 32'(cnt_exp(m_cnt)));
        if (m_valid) begin
            check({tag, ".pc"}, 32'(instr_pc), 32'(m_ipc));
            check({tag, ".out"}, 32'(instr_out), 32'(m_out));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 9'((i * 37 + 11) & 8'hFF);

        #2;
        check("reset.valid", 32'(instr_valid), 0);
        check("reset.addr", 32'(rom_address), 0);
        check("reset.halted", 32'(halted), 0);
        check("reset.pc", 32'(instr_pc), 0);
        check("reset.out", 32'(instr_out), 0);
        check("reset.cnt", 32'(fetch_count), 0);
        reset_n = 1'b1;
        model_reset();
        @(posedge clock);
        #1;

        // start, ready, rv, tgt, valid, pc, addr, halted, cnt
        vq.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 16'd0});
        vq.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h01, 1'b0, 16'd1});
        vq.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 8'h02, 1'b0, 16'd2});
        vq.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 8'h03, 1'b0, 16'd3});
        vq.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 8'h03, 1'b0, 16'd3});
        vq.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 8'h03, 1'b0, 16'd3});
        vq.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 8'h03, 1'b0, 16'd3});
        vq.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 8'h04, 1'b0, 16'd4});
        vq.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 8'h05, 1'b0, 16'd5});
        vq.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 8'h06, 1'b0, 16'd6});
        vq.push_back('{1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 8'h40, 1'b0, 16'd6});
        vq.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 8'h41, 1'b0, 16'd7});
        vq.push_back('{1'b0, 1'b1, 1'b1, 8'hFE, 1'b0, 8'h00, 8'hFE, 1'b0, 16'd7});
        vq.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFE, 8'hFF, 1'b0, 16'd8});
        vq.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b0, 16'd9});
        vq.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h01, 1'b0, 16'd10});
        vq.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 8'h02, 1'b0, 16'd11});

        foreach (vq[i]) begin
            step(vq[i].start, vq[i].ready, vq[i].rv, vq[i].tgt);
            check($sformatf("vec%0d.valid", i), 32'(instr_valid), 32'(vq[i].exp_valid));
            check($sformatf("vec%0d.addr", i), 32'(rom_address), 32'(vq[i].exp_addr));
            check($sformatf("vec%0d.halted", i), 32'(halted), 32'(vq[i].exp_halted));
            check($sformatf("vec%0d.cnt", i), 32'(fetch_count), 32'(cnt_exp(int'(vq[i].exp_cnt))));
            if (vq[i].exp_valid) begin
                check($sformatf("vec%0d.pc", i), 32'(instr_pc), 32'(vq[i].exp_pc));
                check($sformatf("vec%0d.out", i), 32'(instr_out), 32'(rom[vq[i].exp_pc]));
            end
        end

        // Halt word at address 3: presented, held under stall, then drained.
        rom[3] = 9'b1111_00000;
        do_reset();
        step(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        check("halt.pc", 32'(instr_pc), 3);
        check("halt.out", 32'(instr_out), 32'h1E0);
        check("halt.valid", 32'(instr_valid), 1);
        check("halt.halted", 32'(halted), 1);
        step(0, 0, 0, 0);
        check("halt.held", 32'(instr_valid), 1);
        check("halt.held_pc", 32'(instr_pc), 3);
        step(0, 1, 0, 0);
        check("halt.drained", 32'(instr_valid), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 8'h20);
        check("halt.quiet", 32'(instr_valid), 0);
        check("halt.addr", 32'(rom_address), 4);
        step(1, 1, 0, 0);
        check("restart.halted", 32'(halted), 0);
        check("restart.valid", 32'(instr_valid), 0);
        step(0, 1, 0, 0);
        check("restart.valid1", 32'(instr_valid), 1);
        check("restart.pc", 32'(instr_pc), 0);
        check("restart.cnt", 32'(fetch_count), 32'(cnt_exp(1)));

        // Redirect in the cycle the halt word would load: no load, no halt.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("rvhalt.pre", 32'(rom_address), 3);
        step(0, 1, 1, 8'h10);
        check("rvhalt.halted", 32'(halted), 0);
        check("rvhalt.valid", 32'(instr_valid), 0);
        step(0, 1, 0, 0);
        check("rvhalt.pc", 32'(instr_pc), 8'h10);

        // Asynchronous reset mid-run, checked between clock edges.
        step(0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset.valid", 32'(instr_valid), 0);
        check("areset.addr", 32'(rom_address), 0);
        check("areset.halted", 32'(halted), 0);
        check("areset.cnt", 32'(fetch_count), 0);
        #1;
        reset_n = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        check("areset.idle", 32'(instr_valid), 0);

        // Randomized traffic with occasional halt words.
        for (int i = 0; i < 256; i++) begin
            rom[i] = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 9) == 0) rom[i][8:5] = 4'hF;
            else if (rom[i][8:5] == 4'hF) rom[i][8] = 1'b0;
        end
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 5) == 0,
                 8'($urandom_range(0, 255)));
            compare_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
